demux_stream_1xn: RTL and testbench



---
 rtl/demux_stream_1xn.sv | 112 +++++++++++
 tb/tb_demux_stream_1xn.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1xn.sv
// 1-to-N stream demultiplexer: unicast or broadcast words into per-channel
// one-entry output buffers, dropping and counting words with an invalid select.
module demux_stream_1xn #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     err_pulse,
    output logic [7:0]               drop_cnt
);

    // Handshake: a word moves on a rising edge where valid and ready are both
    // high; ready never depends on valid, and a stalled sender holds its payload.
    localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]   full_q;
    logic [DATA_W-1:0] data_q [N_CH];
    logic [N_CH-1:0]   can_take;
    logic [N_CH-1:0]   load;
    logic              sel_ok;
    logic              sel_take;
    logic              xfer;
    logic              drop;
    logic              err_q;
    logic [7:0]        drop_cnt_q;

    // A full buffer that drains this cycle may be refilled in the same cycle.
    assign can_take = ~full_q | out_ready;
    assign sel_ok   = {1'b0, in_sel} < N_CH_W;

    always_comb begin
        sel_take = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_take = can_take[k];
            end
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &can_take;
        end else if (sel_ok) begin
            in_ready = sel_take;
        end
    end

    assign xfer = in_valid && in_ready;
    assign drop = xfer && !in_bcast && !sel_ok;

    // Broadcast only transfers when every channel can take, so it is never partial.
    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = xfer && (in_bcast || (sel_ok && (in_sel == SEL_W'(k))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= load | (full_q & ~out_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_q <= drop;
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign out_data[k*DATA_W +: DATA_W] = data_q[k];
    end

    assign out_valid = full_q;
    assign err_pulse = err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: an 8-channel instance and a 6-channel instance
// (for invalid selects), checked every cycle against a queue-based model.
module tb_demux_stream_1xn;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int N6 = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-channel instance
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data  = '0;
    logic [2:0]        in_sel   = '0;
    logic              in_bcast = 1'b0;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready = '1;
    logic [N*DW-1:0]   out_data;
    logic              err_pulse;
    logic [7:0]        drop_cnt;

    // 6-channel instance
    logic              v6  = 1'b0;
    logic              rdy6;
    logic [DW-1:0]     d6  = '0;
    logic [2:0]        s6  = '0;
    logic              b6  = 1'b0;
    logic [N6-1:0]     ov6;
    logic [N6-1:0]     or6 = '1;
    logic [N6*DW-1:0]  od6;
    logic              err6;
    logic [7:0]        drop6;

    demux_stream_1xn #(.DATA_W(DW), .N_CH(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_pulse(err_pulse), .drop_cnt(drop_cnt)
    );

    demux_stream_1xn #(.DATA_W(DW), .N_CH(N6)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(v6), .in_ready(rdy6), .in_data(d6),
        .in_sel(s6), .in_bcast(b6),
        .out_valid(ov6), .out_ready(or6), .out_data(od6),
        .err_pulse(err6), .drop_cnt(drop6)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q [N][$];
    logic [N-1:0]  ct;
    logic [N-1:0]  exp_ov;
    logic          exp_rdy;
    logic [N6-1:0] exp_ov6;
    logic [N6-1:0] ct6;
    logic [DW-1:0] exp_d6 [N6];
    logic          exp_rdy6;
    logic          exp_err6;
    int            exp_drop6;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            for (int k = 0; k < N; k++) exp_q[k].delete();
            exp_ov6   = '0;
            exp_err6  = 1'b0;
            exp_drop6 = 0;
        end else begin
            // 8-channel: each channel holds at most one queued word
            for (int k = 0; k < N; k++) begin
                ct[k]     = (exp_q[k].size() == 0) || out_ready[k];
                exp_ov[k] = (exp_q[k].size() != 0);
            end
            exp_rdy = in_bcast ? (&ct) : ct[in_sel];
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, exp_ov);
            for (int k = 0; k < N; k++) begin
                if (exp_q[k].size() != 0) chk("out_data", out_data[k*DW +: DW], exp_q[k][0]);
            end
            for (int k = 0; k < N; k++) begin
                if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
            end
            if (in_valid && exp_rdy) begin
                if (in_bcast) begin
                    for (int k = 0; k < N; k++) exp_q[k].push_back(in_data);
                end else begin
                    exp_q[in_sel].push_back(in_data);
                end
            end

            // 6-channel: selects 6 and 7 are invalid and get dropped
            ct6 = ~exp_ov6 | or6;
            if (b6)            exp_rdy6 = &ct6;
            else if (s6 >= 6)  exp_rdy6 = 1'b1;
            else               exp_rdy6 = ct6[s6];
            chk("in_ready6", rdy6, exp_rdy6);
            chk("out_valid6", ov6, exp_ov6);
            chk("err_pulse", err6, exp_err6);
            chk("drop_cnt", drop6, exp_drop6);
            for (int k = 0; k < N6; k++) begin
                if (exp_ov6[k]) chk("out_data6", od6[k*DW +: DW], exp_d6[k]);
            end
            exp_ov6  = exp_ov6 & ~or6;
            exp_err6 = 1'b0;
            if (v6 && exp_rdy6) begin
                if (b6) begin
                    exp_ov6 = '1;
                    for (int k = 0; k < N6; k++) exp_d6[k] = d6;
                end else if (s6 >= 6) begin
                    exp_err6 = 1'b1;
                    if (exp_drop6 < 255) exp_drop6++;
                end else begin
                    exp_ov6[s6] = 1'b1;
                    exp_d6[s6]  = d6;
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic took;
    logic took6;

    initial begin
        // reset values
        @(negedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst drop_cnt", drop6, 0);
        chk("rst err_pulse", err6, 0);
        #2 rst = 1'b0;

        // sweep
        out_ready = '1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sel = 3'(k); in_data = 8'(8'hA0 + k);
            #1;
            chk("sweep in_ready", in_ready, 1);
            if (k > 0) begin
                chk("sweep out_valid", out_valid, 64'd1 << (k - 1));
                chk("sweep data", out_data[(k-1)*DW +: DW], 64'hA0 + k - 1);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("sweep out_valid last", out_valid, 8'h80);
        chk("sweep data last", out_data[7*DW +: DW], 8'hA7);

        // backpressure on channel 3
        @(negedge clk);
        out_ready = 8'hF7; in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h11;
        #1 chk("bp first ready", in_ready, 1);
        @(negedge clk);
        in_data = 8'h22;
        #1;
        chk("bp stalled", in_ready, 0);
        chk("bp held", out_data[3*DW +: DW], 8'h11);
        @(negedge clk);
        #1;
        chk("bp still stalled", in_ready, 0);
        chk("bp still held", out_data[3*DW +: DW], 8'h11);
        @(negedge clk);
        out_ready = 8'hFF;
        #1 chk("bp release ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp out_valid", out_valid, 8'h08);
        chk("bp replaced", out_data[3*DW +: DW], 8'h22);

        // broadcast
        @(negedge clk);
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h5A;
        #1 chk("bc ready", in_ready, 1);
        @(negedge clk);
        in_bcast = 1'b0; in_sel = 3'd6; in_data = 8'h66;
        #1;
        chk("bc out_valid", out_valid, 8'hFF);
        chk("bc data", out_data, 64'h5A5A5A5A5A5A5A5A);
        @(negedge clk);
        in_bcast = 1'b1; in_data = 8'hC3; out_ready = 8'hBF;
        #1;
        chk("bc stalled", in_ready, 0);
        chk("bc stall valid", out_valid, 8'h40);
        @(negedge clk);
        #1;
        chk("bc still stalled", in_ready, 0);
        chk("bc no change", out_data, 64'h5A665A5A5A5A5A5A);
        @(negedge clk);
        out_ready = 8'hFF;
        #1 chk("bc release ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_bcast = 1'b0;
        #1;
        chk("bc2 out_valid", out_valid, 8'hFF);
        chk("bc2 data", out_data, 64'hC3C3C3C3C3C3C3C3);

        // invalid selects on the 6-channel instance
        @(negedge clk);
        v6 = 1'b1; s6 = 3'd2; d6 = 8'h77; or6 = '0;
        #1 chk("inv load ready", rdy6, 1);
        @(negedge clk);
        s6 = 3'd7;
        #1;
        chk("inv ready", rdy6, 1);
        chk("inv no err yet", err6, 0);
        @(negedge clk);
        s6 = 3'd6;
        #1;
        chk("inv err", err6, 1);
        chk("inv cnt1", drop6, 1);
        chk("inv ov held", ov6, 6'h04);
        @(negedge clk);
        v6 = 1'b0;
        #1;
        chk("inv err consec", err6, 1);
        chk("inv cnt2", drop6, 2);
        @(negedge clk);
        #1 chk("inv err low", err6, 0);
        or6 = '1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v6 = 1'b1; s6 = 3'($urandom_range(6, 7));
        end
        @(negedge clk);
        v6 = 1'b0;
        #1;
        chk("sat cnt", drop6, 255);
        chk("sat err", err6, 1);
        @(negedge clk);
        v6 = 1'b1; s6 = 3'd7;
        @(negedge clk);
        v6 = 1'b0;
        #1;
        chk("sat pulse", err6, 1);
        chk("sat hold", drop6, 255);

        // asynchronous reset with every channel full
        out_ready = '0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sel = 3'(k); in_data = 8'(8'h30 + k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("ar full", out_valid, 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("ar out_valid", out_valid, 0);
        chk("ar out_data", out_data, 0);
        chk("ar drop_cnt", drop6, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h99;
        #1 chk("ar post ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ar post valid", out_valid, 8'h10);
        chk("ar post data", out_data[4*DW +: DW], 8'h99);

        // random traffic
        took = 1'b0; took6 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!(in_valid && !took)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom_range(0, 7));
                in_bcast = ($urandom_range(0, 7) == 0);
                in_data  = 8'($urandom);
            end
            out_ready = 8'($urandom) | 8'($urandom);
            if (!(v6 && !took6)) begin
                v6 = ($urandom_range(0, 1) != 0);
                s6 = 3'($urandom_range(0, 7));
                b6 = ($urandom_range(0, 9) == 0);
                d6 = 8'($urandom);
            end
            or6 = 6'($urandom | $urandom);
            #4;
            took  = in_valid && in_ready;
            took6 = v6 && rdy6;
        end
        @(negedge clk);
        in_valid = 1'b0; v6 = 1'b0; b6 = 1'b0;
        out_ready = '1; or6 = '1;
        repeat (3) @(negedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
